// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search datapath: checker FSM state
// encoding, default message length and the legal-plaintext character bounds.
// Also used by the decode core and the key-search controller.
package rc4_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        CHECK,
        DONE
    } checker_state_t;

    localparam int         MSG_LEN_DEFAULT = 32;
    localparam logic [7:0] CHAR_LO         = 8'd97;   // 'a'
    localparam logic [7:0] CHAR_HI         = 8'd122;  // 'z'
    localparam logic [7:0] CHAR_SP         = 8'd32;   // ' '

endpackage

// File: rtl/char_is_legal.sv
// Combinational plaintext classifier: a byte is legal when it is a lowercase
// letter in [CHAR_LO, CHAR_HI] or exactly CHAR_SP. All compares are unsigned.
// Ports:
//   q     in  8  byte under test
//   legal out 1  1 = legal plaintext character
module char_is_legal #(
    parameter logic [7:0] CHAR_LO = rc4_pkg::CHAR_LO,
    parameter logic [7:0] CHAR_HI = rc4_pkg::CHAR_HI,
    parameter logic [7:0] CHAR_SP = rc4_pkg::CHAR_SP
) (
    input  logic [7:0] q,
    output logic       legal
);

    assign legal = ((q >= CHAR_LO) && (q <= CHAR_HI)) || (q == CHAR_SP);

endmodule

// File: rtl/decr_msg_checker.sv
// Scans the decrypted-message RAM after an RC4 decode pass and reports whether
// every byte is legal plaintext, how many bytes are illegal and where the
// first illegal byte sits. Each byte takes three cycles (ADDR, WAIT, CHECK)
// because the RAM registers the address and its data is sampled a cycle later.
// Optional build macro CHECKER_EARLY_EXIT_EN: stop the scan at the first
// illegal byte instead of scanning the whole message.
// Ports:
//   clk            in   1         system clock
//   reset          in   1         asynchronous active-high reset
//   start          in   1         level scan request, sampled only in IDLE
//   decr_mem_addr  out  ADDR_W    registered RAM read address
//   decr_mem_q     in   8         RAM read data (one cycle after address)
//   finish         out  1         high in DONE; results valid
//   msg_valid      out  1         1 = no illegal byte seen
//   bad_count      out  ADDR_W+1  illegal byte count, saturates at MSG_LEN
//   first_bad_addr out  ADDR_W    address of first illegal byte, 0 if none
module decr_msg_checker
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEFAULT,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] decr_mem_addr,
    input  logic [7:0]        decr_mem_q,
    output logic              finish,
    output logic              msg_valid,
    output logic [ADDR_W:0]   bad_count,
    output logic [ADDR_W-1:0] first_bad_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);
    localparam logic [ADDR_W:0]   BAD_MAX   = (ADDR_W + 1)'(MSG_LEN);

    checker_state_t    state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   bad_count_q, bad_count_d;
    logic [ADDR_W-1:0] first_bad_q, first_bad_d;
    logic              msg_valid_q, msg_valid_d;

    logic byte_legal;
    logic last_byte;
    logic scan_end;

    char_is_legal u_classify (
        .q     (decr_mem_q),
        .legal (byte_legal)
    );

    assign last_byte = (addr_q == LAST_ADDR);

`ifdef CHECKER_EARLY_EXIT_EN
    assign scan_end = last_byte || !byte_legal;
`else
    assign scan_end = last_byte;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            bad_count_q <= '0;
            first_bad_q <= '0;
            msg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bad_count_q <= bad_count_d;
            first_bad_q <= first_bad_d;
            msg_valid_q <= msg_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        bad_count_d = bad_count_q;
        first_bad_d = first_bad_q;
        msg_valid_d = msg_valid_q;

        case (state_q)
            IDLE: begin
                // Results of the previous scan stay visible until a new start.
                if (start) begin
                    addr_d      = '0;
                    bad_count_d = '0;
                    first_bad_d = '0;
                    msg_valid_d = 1'b0;
                    state_d     = ADDR;
                end
            end
            ADDR:  state_d = WAIT;
            WAIT:  state_d = CHECK;
            CHECK: begin
                if (!byte_legal) begin
                    if (bad_count_q == '0) begin
                        first_bad_d = addr_q;
                    end
                    if (bad_count_q != BAD_MAX) begin
                        bad_count_d = bad_count_q + (ADDR_W + 1)'(1);
                    end
                end
                if (scan_end) begin
                    // Verdict uses the count including the byte just checked.
                    msg_valid_d = (bad_count_d == '0);
                    state_d     = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = ADDR;
                end
            end
            DONE: begin
                // Holding start keeps the result; a new scan needs a fresh edge.
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign decr_mem_addr  = addr_q;
    assign finish         = (state_q == DONE);
    assign msg_valid      = msg_valid_q;
    assign bad_count      = bad_count_q;
    assign first_bad_addr = first_bad_q;

endmodule

// File: tb/tb_decr_msg_checker.sv
module tb_decr_msg_checker;

    localparam int MSG_LEN = 32;
    localparam int ADDR_W  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] decr_mem_addr;
    logic [7:0]        decr_mem_q;
    logic              finish;
    logic              msg_valid;
    logic [ADDR_W:0]   bad_count;
    logic [ADDR_W-1:0] first_bad_addr;

    logic [7:0] mem [MSG_LEN];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Synchronous-read RAM model: data appears one clock after the address.
    always @(posedge clk) decr_mem_q <= mem[decr_mem_addr];

    decr_msg_checker #(
        .MSG_LEN (MSG_LEN),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .decr_mem_addr  (decr_mem_addr),
        .decr_mem_q     (decr_mem_q),
        .finish         (finish),
        .msg_valid      (msg_valid),
        .bad_count      (bad_count),
        .first_bad_addr (first_bad_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_plain(input logic [7:0] b);
        return (b >= "a" && b <= "z") || b == " ";
    endfunction

    // Expected scan outcome derived directly from the message contents.
    task automatic model(output int cnt, output int first, output int lat, output int addr);
        cnt   = 0;
        first = 0;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (!is_plain(mem[i])) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
        lat  = 3 * MSG_LEN;
        addr = MSG_LEN - 1;
`ifdef CHECKER_EARLY_EXIT_EN
        if (cnt > 0) begin
            cnt  = 1;
            lat  = 3 * (first + 1);
            addr = first;
        end
`endif
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < MSG_LEN; i++) mem[i] = v;
    endtask

    // Raise start, check the clear on the sampling edge, then count edges
    // until finish (bounded). lat = -1 if finish never came.
    task automatic run_scan(input string tag, input bit hold, output int lat);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        check({tag, ".clr_cnt"},   bad_count, 0);
        check({tag, ".clr_first"}, first_bad_addr, 0);
        check({tag, ".clr_valid"}, msg_valid, 0);
        lat = -1;
        for (int n = 1; n <= 4 * MSG_LEN; n++) begin
            @(posedge clk);
            #1;
            if (finish) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic verify(input string tag, input bit hold);
        int cnt, first, lat, addr, got_lat;
        model(cnt, first, lat, addr);
        run_scan(tag, hold, got_lat);
        check({tag, ".latency"}, got_lat, lat);
        check({tag, ".finish"},  finish, 1);
        check({tag, ".valid"},   msg_valid, (cnt == 0));
        check({tag, ".count"},   bad_count, cnt);
        check({tag, ".first"},   first_bad_addr, first);
        check({tag, ".addr"},    decr_mem_addr, addr);
        if (!hold) begin
            @(posedge clk);
            #1;
            check({tag, ".idle_finish"}, finish, 0);
            check({tag, ".idle_count"},  bad_count, cnt);
            check({tag, ".idle_valid"},  msg_valid, (cnt == 0));
        end
    endtask

    initial begin
        int cnt, first, lat, addr;
        reset = 1'b1;
        start = 1'b0;
        fill("a");
        repeat (3) @(posedge clk);
        #1;
        check("rst.finish", finish, 0);
        check("rst.valid",  msg_valid, 0);
        check("rst.count",  bad_count, 0);
        check("rst.first",  first_bad_addr, 0);
        check("rst.addr",   decr_mem_addr, 0);
        @(negedge clk);
        reset = 1'b0;

        // All 'a'.
        fill(8'h61);
        verify("clean", 1'b0);

        // Two illegal bytes in a field of 'z'.
        fill(8'h7A);
        mem[5]  = 8'h41;
        mem[20] = 8'h7B;
        verify("two_bad", 1'b0);

        // Values just outside and on the legal boundaries.
        fill(8'h61);
        mem[0] = 8'h60; mem[1] = 8'h7B; mem[2] = 8'h1F; mem[3] = 8'h21;
        mem[4] = 8'h61; mem[5] = 8'h7A; mem[6] = 8'h20;
        verify("bounds", 1'b0);
`ifndef CHECKER_EARLY_EXIT_EN
        check("bounds.count4", bad_count, 4);
`endif

        // Single NUL at address 3.
        fill(8'h20);
        mem[3] = 8'h00;
        verify("nul3", 1'b0);

        // Random messages, mostly legal with scattered random bytes.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                if ($urandom_range(0, 9) < 2) mem[i] = 8'($urandom_range(0, 255));
                else if ($urandom_range(0, 5) == 0) mem[i] = 8'h20;
                else mem[i] = 8'($urandom_range(97, 122));
            end
            if (r == 0) fill(8'h20);
            verify($sformatf("rand%0d", r), 1'b0);
        end

        // Asynchronous reset in the middle of a scan.
        fill(8'h61);
        mem[2] = 8'hFF;
        mem[9] = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst.finish", finish, 0);
        check("midrst.valid",  msg_valid, 0);
        check("midrst.count",  bad_count, 0);
        check("midrst.first",  first_bad_addr, 0);
        check("midrst.addr",   decr_mem_addr, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        verify("after_rst", 1'b0);

        // Hold start through DONE: no rescan, results frozen.
        fill(8'h7A);
        mem[7] = 8'h5B;
        verify("hold", 1'b1);
        model(cnt, first, lat, addr);
        repeat (10) @(posedge clk);
        #1;
        check("hold.finish", finish, 1);
        check("hold.count",  bad_count, cnt);
        check("hold.first",  first_bad_addr, first);
        check("hold.addr",   decr_mem_addr, addr);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("hold.drop_finish", finish, 0);
        fill(8'h61);
        verify("hold.rescan", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decr_msg_checker.md
Name: decr_msg_checker

Overview:
- Reader for the decrypted-message RAM written by the RC4 decode core.
- After a decode pass, scans all MSG_LEN bytes of decr_mem through its read port and classifies each byte as legal plaintext (lowercase a–z or space) or illegal.
- Reports pass/fail, illegal-byte count and first illegal address to the key-search controller, which uses the verdict to accept or reject the current key.

Parameters:
- MSG_LEN, 32, number of message bytes scanned (addresses 0..MSG_LEN-1).
- ADDR_W, 5, decr_mem address width; must satisfy 2**ADDR_W >= MSG_LEN.
- CHAR_LO, 8'd97, lowest legal letter ('a').
- CHAR_HI, 8'd122, highest legal letter ('z').
- CHAR_SP, 8'd32, the one legal non-letter (space).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  level request; sampled only in IDLE.
- decr_mem_addr  out  ADDR_W  read address to decr_mem; registered.
- decr_mem_q  in  8  read data; valid one clock after decr_mem_addr is presented (synchronous RAM, unregistered output).
- finish  out  1  high in DONE; results valid while high.
- msg_valid  out  1  1 = every scanned byte legal; meaningful only while finish=1.
- bad_count  out  ADDR_W+1  number of illegal bytes (saturates at MSG_LEN).
- first_bad_addr  out  ADDR_W  address of the first illegal byte; 0 if none.

Behaviour:
- Reset (async, active-high): state=IDLE; decr_mem_addr=0, finish=0, msg_valid=0, bad_count=0, first_bad_addr=0.
- A reset asserted mid-scan aborts the scan. No partial results are retained.
- States: IDLE, ADDR, WAIT, CHECK, DONE.
- IDLE:
  - start=1 → clear bad_count, first_bad_addr and msg_valid; set decr_mem_addr=0; go to ADDR.
  - start=0 → stay in IDLE.
- ADDR → WAIT: RAM registers the address.
- WAIT → CHECK: decr_mem_q is stable.
- CHECK:
  - A byte is legal iff (CHAR_LO <= q <= CHAR_HI) or q == CHAR_SP. Comparisons are unsigned 8-bit.
  - Illegal byte: increment bad_count. If it is the first illegal byte, latch first_bad_addr = decr_mem_addr.
  - If decr_mem_addr == MSG_LEN-1 → go to DONE. Otherwise increment decr_mem_addr and go to ADDR.
  - The address never wraps past MSG_LEN-1.
- DONE:
  - finish=1 and msg_valid = (bad_count == 0).
  - Outputs are held while start=1. When start=0 → IDLE, and finish drops on that edge.
  - Results persist in IDLE until the next start.
- Latency:
  - 3 cycles per byte.
  - Full scan: finish rises on the 3*MSG_LEN-th rising edge after the edge that sampled start (96 for default).
- Simultaneous events:
  - start toggling outside IDLE/DONE is ignored.
  - start already high when DONE is entered does not retrigger a scan; it must be deasserted and reasserted.
- decr_mem_addr changes only on the ADDR-bound transition out of CHECK or on scan start.

Optional Feature:
- Macro: CHECKER_EARLY_EXIT_EN.
- Defined: CHECK goes to DONE on the first illegal byte. bad_count is then 1 and first_bad_addr is that address. finish rises 3*(i+1) edges after start for illegal byte i.
- Undefined: all MSG_LEN bytes are always scanned, and bad_count is the total number of illegal bytes.

Decomposition:
- Shared package rc4_pkg holds:
  - the state enum typedef checker_state_t {IDLE, ADDR, WAIT, CHECK, DONE};
  - constants MSG_LEN_DEFAULT=32, CHAR_LO/CHAR_HI/CHAR_SP, which are shared with the decode core and key-search controller.
- One sub-module: char_is_legal, a combinational 8-bit classifier (q → legal), reused by the controller's debug logic.
- FSM and counters stay in decr_msg_checker.

Test Plan:
- RAM preloaded with 32×0x61 ('a'); pulse start high → finish=1 at edge 96, msg_valid=1, bad_count=0, first_bad_addr=0.
- Byte 5=0x41, byte 20=0x7B, rest 0x7A; macro off → finish at edge 96, msg_valid=0, bad_count=2, first_bad_addr=5.
- Boundary bytes:
  - 0x60, 0x7B, 0x1F, 0x21 at addresses 0–3 are each counted illegal.
  - 0x61, 0x7A, 0x20 at addresses 4–6 are legal.
  - Result: bad_count=4, first_bad_addr=0.
- Macro on, byte 3=0x00 → finish at edge 12, bad_count=1, first_bad_addr=3, decr_mem_addr stays 3.
- Assert reset at cycle 40 of a scan → all outputs 0 immediately (async). Reassert start after release → full fresh scan with correct results.
- Hold start high through DONE → finish stays 1 with no rescan. Drop start, load a clean message, raise start → results cleared at start, then msg_valid=1.
